// File: rtl/binary_div_8_4_bi.sv
// ----------------------------------------------------------------------------
// binary_div_8_4_bi
// Sequential signed divider: 8-bit dividend by 4-bit divisor, producing an
// 8-bit quotient and a 4-bit remainder that truncate toward zero (the same
// results as Verilog / and %). The magnitudes are divided by a restoring
// shift-subtract loop, one quotient bit per clock, and the signs are applied
// at the end.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   start     in   request a division (accepted only while idle)
//   N[7:0]    in   signed dividend
//   D[3:0]    in   signed divisor
//   Q[7:0]    out  signed quotient (registered, held until next done)
//   R[3:0]    out  signed remainder (registered, held until next done)
//   busy      out  high while a division is in flight
//   done      out  one-cycle pulse when Q, R and the flags update
//   div_zero  out  divisor was zero for the latest result
//   overflow  out  -128 / -1: quotient does not fit, Q reads 8'h80
// ----------------------------------------------------------------------------
module binary_div_8_4_bi (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] N,
   input  logic [3:0] D,
   output logic [7:0] Q,
   output logic [3:0] R,
   output logic       busy,
   output logic       done,
   output logic       div_zero,
   output logic       overflow
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } state_t;

   state_t      state_q,      state_d;
   logic [2:0]  cnt_q,        cnt_d;
   logic [7:0]  dividend_q,   dividend_d;
   logic [3:0]  divisorMag_q, divisorMag_d;
   logic [3:0]  rem_q,        rem_d;
   logic [7:0]  quo_q,        quo_d;
   logic        qSign_q,      qSign_d;
   logic        rSign_q,      rSign_d;
   logic        zeroPend_q,   zeroPend_d;
   logic [7:0]  resQ_q,       resQ_d;
   logic [3:0]  resR_q,       resR_d;
   logic        busy_q,       busy_d;
   logic        done_q,       done_d;
   logic        divZero_q,    divZero_d;
   logic        overflow_q,   overflow_d;

   logic [4:0]  trialShift;
   logic        borrow;
   logic [3:0]  trialDiff;

   // The partial remainder stays below |D| <= 8, so after the shift it fits
   // in five bits. When there is no borrow the true difference is below 16,
   // so a 4-bit modular subtract is exact.
   always_comb begin
      trialShift = {rem_q, dividend_q[7]};
      borrow     = (trialShift < {1'b0, divisorMag_q});
      trialDiff  = trialShift[3:0] - divisorMag_q;
   end

   // Next-state and datapath logic. A zero divisor does not enter CALC:
   // it parks in IDLE for one cycle with zeroPend set so the result still
   // arrives one clock after acceptance with busy high in between.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      dividend_d   = dividend_q;
      divisorMag_d = divisorMag_q;
      rem_d        = rem_q;
      quo_d        = quo_q;
      qSign_d      = qSign_q;
      rSign_d      = rSign_q;
      zeroPend_d   = zeroPend_q;
      resQ_d       = resQ_q;
      resR_d       = resR_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      divZero_d    = divZero_q;
      overflow_d   = overflow_q;

      case (state_q)
         IDLE: begin
            if (zeroPend_q) begin
               zeroPend_d = 1'b0;
               busy_d     = 1'b0;
               done_d     = 1'b1;
               divZero_d  = 1'b1;
               overflow_d = 1'b0;
               resQ_d     = 8'd0;
               resR_d     = 4'd0;
            end else if (start) begin
               busy_d = 1'b1;
               if (D == 4'd0) begin
                  zeroPend_d = 1'b1;
               end else begin
                  state_d      = CALC;
                  cnt_d        = 3'd0;
                  dividend_d   = N[7] ? (8'd0 - N) : N;
                  divisorMag_d = D[3] ? (4'd0 - D) : D;
                  rem_d        = 4'd0;
                  quo_d        = 8'd0;
                  qSign_d      = N[7] ^ D[3];
                  rSign_d      = N[7];
               end
            end
         end

         CALC: begin
            dividend_d = {dividend_q[6:0], 1'b0};
            rem_d      = borrow ? trialShift[3:0] : trialDiff;
            quo_d      = {quo_q[6:0], ~borrow};
            cnt_d      = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               state_d = SIGN;
            end
         end

         SIGN: begin
            // A positive quotient with its MSB set can only be 128 from
            // -128 / -1; that is the sole overflow case.
            resQ_d     = qSign_q ? (8'd0 - quo_q) : quo_q;
            resR_d     = rSign_q ? (4'd0 - rem_q) : rem_q;
            overflow_d = ~qSign_q & quo_q[7];
            divZero_d  = 1'b0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            state_d    = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register with synchronous reset; reset wins over start and
   // aborts any division in flight without a done pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= 3'd0;
         dividend_q   <= 8'd0;
         divisorMag_q <= 4'd0;
         rem_q        <= 4'd0;
         quo_q        <= 8'd0;
         qSign_q      <= 1'b0;
         rSign_q      <= 1'b0;
         zeroPend_q   <= 1'b0;
         resQ_q       <= 8'd0;
         resR_q       <= 4'd0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         divZero_q    <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         dividend_q   <= dividend_d;
         divisorMag_q <= divisorMag_d;
         rem_q        <= rem_d;
         quo_q        <= quo_d;
         qSign_q      <= qSign_d;
         rSign_q      <= rSign_d;
         zeroPend_q   <= zeroPend_d;
         resQ_q       <= resQ_d;
         resR_q       <= resR_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         divZero_q    <= divZero_d;
         overflow_q   <= overflow_d;
      end
   end

   assign Q        = resQ_q;
   assign R        = resR_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign div_zero = divZero_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_binary_div_8_4_bi.sv
// ----------------------------------------------------------------------------
// tb_binary_div_8_4_bi
// Self-checking bench for binary_div_8_4_bi. Stimulus pushes the expected
// result (value, flags and the edge at which done must appear) into a
// scoreboard queue; an independent monitor pops and compares on every done.
// ----------------------------------------------------------------------------
module tb_binary_div_8_4_bi;

   logic       clk;
   logic       rst;
   logic       start;
   logic [7:0] N;
   logic [3:0] D;
   logic [7:0] Q;
   logic [3:0] R;
   logic       busy;
   logic       done;
   logic       div_zero;
   logic       overflow;

   typedef struct {
      int q;
      int r;
      int dz;
      int ov;
      int doneEdge;
   } exp_t;

   exp_t sb[$];
   int   checks;
   int   errors;
   int   edgeCount;

   binary_div_8_4_bi dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .N        (N),
      .D        (D),
      .Q        (Q),
      .R        (R),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .overflow (overflow)
   );

   // Free-running clock and an edge counter used to time results.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) edgeCount <= edgeCount + 1;

   // Single comparison point shared by the monitor and the directed checks.
   task automatic checkOutput(input string name, input int actual, input int required);
      checks++;
      if (actual !== required) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, required);
      end
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (done) begin
         if (sb.size() == 0) begin
            checkOutput("unexpected_done", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            checkOutput("Q",        int'(Q),        e.q);
            checkOutput("R",        int'(R),        e.r);
            checkOutput("div_zero", int'(div_zero), e.dz);
            checkOutput("overflow", int'(overflow), e.ov);
            checkOutput("busy_at_done", int'(busy), 0);
            checkOutput("done_edge", edgeCount, e.doneEdge);
         end
      end
   end

   // Called at #1 after a rising edge; the next edge samples start.
   task automatic applyStimulus(input int n, input int d, input int expQ, input int expR,
                                input int expDz, input int expOv, input bit push);
      exp_t e;
      start = 1'b1;
      N     = 8'(n);
      D     = 4'(d);
      e.q   = expQ & 255;
      e.r   = expR & 15;
      e.dz  = expDz;
      e.ov  = expOv;
      e.doneEdge = edgeCount + 1 + ((d == 0) ? 1 : 9);
      if (push) sb.push_back(e);
      @(posedge clk);
      #1;
      start = 1'b0;
      N     = 8'($urandom);
      D     = 4'($urandom);
   endtask

   task automatic waitCycles(input int k);
      repeat (k) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Bounded wait for done; leaves the caller at #1 after the done edge.
   task automatic waitDone();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) checkOutput("done_timeout", 0, 1);
   endtask

   // Sweep reference: integer division truncating toward zero.
   task automatic sweepOne(input int n, input int d);
      int q;
      int r;
      if (d == 0) begin
         applyStimulus(n, d, 0, 0, 1, 0, 1'b1);
      end else begin
         q = n / d;
         r = n % d;
         applyStimulus(n, d, q, r, 0, ((n == -128) && (d == -1)) ? 1 : 0, 1'b1);
      end
      waitDone();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      checks    = 0;
      errors    = 0;
      edgeCount = 0;
      rst       = 1'b1;
      start     = 1'b0;
      N         = 8'd0;
      D         = 4'd0;

      // Reset state.
      waitCycles(3);
      checkOutput("reset_Q",        int'(Q),        0);
      checkOutput("reset_R",        int'(R),        0);
      checkOutput("reset_busy",     int'(busy),     0);
      checkOutput("reset_done",     int'(done),     0);
      checkOutput("reset_div_zero", int'(div_zero), 0);
      checkOutput("reset_overflow", int'(overflow), 0);

      // 100 / 7 with start in the first edge after reset releases.
      rst = 1'b0;
      applyStimulus(100, 7, 14, 2, 0, 0, 1'b1);
      checkOutput("busy_edge0", int'(busy), 1);
      for (int i = 1; i <= 8; i++) begin
         waitCycles(1);
         checkOutput("busy_calc", int'(busy), 1);
      end
      waitCycles(1);
      checkOutput("done_edge9", int'(done), 1);
      checkOutput("busy_edge9", int'(busy), 0);
      waitCycles(1);
      checkOutput("done_edge10", int'(done), 0);
      checkOutput("Q_hold",      int'(Q),    14);

      // Sign cases and boundaries (hand-computed).
      applyStimulus(-100,  7, -14, -2, 0, 0, 1'b1); waitDone();
      applyStimulus( 100, -7, -14,  2, 0, 0, 1'b1); waitDone();
      applyStimulus(-100, -7,  14, -2, 0, 0, 1'b1); waitDone();
      applyStimulus(  -8, -8,   1,  0, 0, 0, 1'b1); waitDone();
      applyStimulus(-128, -1, 128,  0, 0, 1, 1'b1); waitDone();
      applyStimulus( 127,  1, 127,  0, 0, 0, 1'b1); waitDone();
      applyStimulus(  55,  0,   0,  0, 1, 0, 1'b1);
      checkOutput("busy_dz_edge0", int'(busy), 1);
      waitCycles(1);
      checkOutput("done_dz_edge1", int'(done), 1);
      checkOutput("busy_dz_edge1", int'(busy), 0);
      waitCycles(1);

      // Start while busy is ignored; start in the done cycle is accepted.
      applyStimulus(100, 7, 14, 2, 0, 0, 1'b1);
      waitCycles(2);
      applyStimulus(50, 5, 0, 0, 0, 0, 1'b0);
      waitDone();
      applyStimulus(50, 5, 10, 0, 0, 0, 1'b1);
      waitDone();

      // Reset mid-operation aborts; restart afterwards.
      applyStimulus(100, 7, 0, 0, 0, 0, 1'b0);
      waitCycles(3);
      rst = 1'b1;
      waitCycles(1);
      checkOutput("abort_Q",    int'(Q),    0);
      checkOutput("abort_R",    int'(R),    0);
      checkOutput("abort_busy", int'(busy), 0);
      checkOutput("abort_done", int'(done), 0);
      rst = 1'b0;
      waitCycles(1);
      applyStimulus(9, 2, 4, 1, 0, 0, 1'b1);
      waitDone();

      // Reset takes priority over start.
      rst   = 1'b1;
      start = 1'b1;
      N     = 8'd100;
      D     = 4'd7;
      waitCycles(1);
      rst   = 1'b0;
      start = 1'b0;
      waitCycles(2);
      checkOutput("rst_priority_busy", int'(busy), 0);

      // Exhaustive sweep: every nonzero divisor, then every zero divisor.
      for (int n = -128; n <= 127; n++) begin
         for (int d = -8; d <= 7; d++) begin
            if (d != 0) sweepOne(n, d);
         end
      end
      for (int n = -128; n <= 127; n++) sweepOne(n, 0);

      waitCycles(3);
      checkOutput("scoreboard_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
